// File: rtl/stream_selector_n_to_1_pkg.sv
// Shared definitions for the N-to-1 stream selector.
//   MODE_*        : encodings of the 2-bit mode input (2'b11 behaves as round-robin)
//   *_DEF         : default channel count / data width / index width
//   out_state_e   : output register occupancy
package stream_selector_n_to_1_pkg;

  localparam logic [1:0] MODE_FIXED = 2'b00;
  localparam logic [1:0] MODE_PRIO  = 2'b01;
  localparam logic [1:0] MODE_RR    = 2'b10;

  localparam int unsigned CHANNELS_DEF = 4;
  localparam int unsigned WIDTH_DEF    = 8;
  localparam int unsigned SEL_W_DEF    = 2;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/stream_selector_n_to_1_rr_arbiter.sv
// Combinational search arbiter shared by the fixed-priority and round-robin modes.
//   req           : per-channel request vector
//   ptr           : round-robin start index (ignored when priority_only=1)
//   priority_only : 1 = search from channel 0, 0 = search from ptr with wrap
//   grant         : winning channel index (0 when nothing granted)
//   grant_valid   : at least one request found
module rr_arbiter
  import stream_selector_n_to_1_pkg::*;
#(
  parameter int unsigned CHANNELS = CHANNELS_DEF,
  parameter int unsigned SEL_W    = SEL_W_DEF
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  input  logic                priority_only,
  output logic [SEL_W-1:0]    grant,
  output logic                grant_valid
);

  int unsigned start;
  int unsigned idx;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    start       = priority_only ? 0 : 32'(ptr);
    // First hit wins; later hits are masked by grant_valid.
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      idx = (start + k) % CHANNELS;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant       = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_selector_n_to_1.sv
// Registered N-to-1 valid/ready stream selector with a one-entry output register.
//   clk, rst   : clock, synchronous active-high reset
//   mode       : 00 fixed-select, 01 fixed-priority, 1x round-robin
//   sel        : channel index for fixed-select mode
//   in_data    : flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   : per-channel valid
//   in_ready   : per-channel ready (combinational, one-hot or zero)
//   out_data   : registered selected data
//   out_chan   : registered source channel index
//   out_valid  : output register holds data
//   out_ready  : consumer accepts data
module stream_selector_n_to_1
  import stream_selector_n_to_1_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned CHANNELS = CHANNELS_DEF,
  parameter int unsigned SEL_W    = SEL_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] data_q;
  logic [SEL_W-1:0] chan_q;
  logic [SEL_W-1:0] ptr_q;

  logic [SEL_W-1:0] arb_grant;
  logic             arb_valid;
  logic [SEL_W-1:0] g;
  logic             g_valid;
  logic             mode_rr;
  logic             load;
  logic             in_xfer;
  logic [WIDTH-1:0] g_data;

  assign mode_rr = mode[1];
  assign load    = (state_q == ST_EMPTY) | out_ready;

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_arb (
    .req           (in_valid),
    .ptr           (ptr_q),
    .priority_only (!mode_rr),
    .grant         (arb_grant),
    .grant_valid   (arb_valid)
  );

  // Fixed-select bypasses the arbiter; an out-of-range sel never grants.
  always_comb begin
    g       = arb_grant;
    g_valid = arb_valid;
    if (mode == MODE_FIXED) begin
      g       = sel;
      g_valid = 1'b0;
      if (32'(sel) < CHANNELS) g_valid = in_valid[sel];
    end
  end

  always_comb begin
    g_data = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (SEL_W'(i) == g) g_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // A granted channel is always valid, so ready alone implies the transfer.
  assign in_xfer  = load & g_valid & !rst;
  assign in_ready = in_xfer ? (CHANNELS'(1) << g) : '0;

  always_comb begin
    state_d = state_q;
    if (in_xfer)                               state_d = ST_FULL;
    else if (state_q == ST_FULL && out_ready)  state_d = ST_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      chan_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (in_xfer) begin
        data_q <= g_data;
        chan_q <= g;
        if (mode_rr) ptr_q <= (32'(g) == CHANNELS - 1) ? '0 : g + SEL_W'(1);
      end
    end
  end

  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_stream_selector_n_to_1.sv
module tb_stream_selector_n_to_1;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;

  int unsigned total  = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  stream_selector_n_to_1 #(
    .WIDTH    (8),
    .CHANNELS (4),
    .SEL_W    (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    mode      = 2'b10;
    sel       = 2'd0;
    in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #1;
    chk("rst_in_ready_pre", 32'(in_ready), 32'h0);

    // Reset held two cycles with all channels valid
    step();
    chk("rst_in_ready_c1", 32'(in_ready), 32'h0);
    step();
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_chan", 32'(out_chan), 32'h0);

    // Round-robin from ptr=0, wraps after channel 3
    rst = 1'b0;
    #1;
    chk("rr_first_ready", 32'(in_ready), 32'h1);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_chan", 32'(out_chan), 32'(k % 4));
      chk("rr_data", 32'(out_data), 32'hA0 + 32'(k % 4));
      chk("rr_valid", 32'(out_valid), 32'h1);
    end

    // Load 8'h55 from channel 0 (ptr back at 0, becomes 1)
    in_data[7:0] = 8'h55;
    in_valid     = 4'b0001;
    step();
    chk("bp_load_data", 32'(out_data), 32'h55);
    chk("bp_load_chan", 32'(out_chan), 32'h0);

    // Backpressure: held 3 cycles, nothing ready
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    #1;
    chk("bp_in_ready_0", 32'(in_ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_hold_data", 32'(out_data), 32'h55);
      chk("bp_hold_valid", 32'(out_valid), 32'h1);
      chk("bp_in_ready", 32'(in_ready), 32'h0);
    end

    // Release: ptr still 1, so channel 1 replaces on the same edge
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'h2);
    step();
    chk("bp_replace_data", 32'(out_data), 32'hA1);
    chk("bp_replace_chan", 32'(out_chan), 32'h1);
    chk("bp_replace_valid", 32'(out_valid), 32'h1);

    // Fixed-select sel=2
    mode = 2'b00;
    sel  = 2'd2;
    #1;
    chk("fs_in_ready", 32'(in_ready), 32'h4);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("fs_data", 32'(out_data), 32'hA2);
      chk("fs_chan", 32'(out_chan), 32'h2);
      chk("fs_in_ready_c", 32'(in_ready), 32'h4);
    end

    // sel=3 with channel 3 idle: register drains, data holds
    sel      = 2'd3;
    in_valid = 4'b0111;
    #1;
    chk("fs_idle_ready", 32'(in_ready), 32'h0);
    step();
    chk("fs_idle_valid", 32'(out_valid), 32'h0);
    chk("fs_idle_data", 32'(out_data), 32'hA2);
    chk("fs_idle_chan", 32'(out_chan), 32'h2);

    // Fixed priority: channel 1 beats 3 until it drops
    mode     = 2'b01;
    in_valid = 4'b1010;
    #1;
    chk("fp_ready", 32'(in_ready), 32'h2);
    step();
    chk("fp_chan_a", 32'(out_chan), 32'h1);
    step();
    chk("fp_chan_b", 32'(out_chan), 32'h1);
    in_valid = 4'b1000;
    #1;
    chk("fp_ready3", 32'(in_ready), 32'h8);
    step();
    chk("fp_chan3", 32'(out_chan), 32'h3);
    chk("fp_data3", 32'(out_data), 32'hA3);

    // Non-RR modes left ptr at 2
    mode     = 2'b11;
    in_valid = 4'b1111;
    #1;
    chk("rr_ptr_kept", 32'(in_ready), 32'h4);

    // Reset mid-stream while FULL
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(in_ready), 32'h0);
    out_ready = 1'b0;
    #1;
    chk("mid_rst_ready_bp", 32'(in_ready), 32'h0);
    step();
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_data", 32'(out_data), 32'h0);
    chk("mid_rst_chan", 32'(out_chan), 32'h0);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("mid_rst_ptr0", 32'(in_ready), 32'h1);
    step();
    chk("post_rst_chan", 32'(out_chan), 32'h0);
    chk("post_rst_data", 32'(out_data), 32'hA0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/stream_selector_n_to_1.md
# stream_selector_n_to_1

Registered N-to-1 stream selector for the lab datapath. It is the parametrised successor to the plain 2-to-1 selector. It picks one of CHANNELS valid/ready input streams by external select, fixed priority or round-robin, and holds the winner in a one-entry output register. Sits between producer channels (ALU, counters, register file ports) and a single consumer such as the display or bus interface.

## Interface
- WIDTH, 8, data width per channel
- CHANNELS, 4, number of input channels (≥2)
- SEL_W, 2, select/channel-index width; must satisfy 2^SEL_W ≥ CHANNELS
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous and active-high
- mode  input  2  00 fixed-select, 01 fixed-priority, 10 round-robin, 11 treated as round-robin
- sel  input  SEL_W  channel index used in fixed-select mode
- in_data  input  CHANNELS*WIDTH  flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel valid
- in_ready  output  CHANNELS  per-channel ready, combinational
- out_data  output  WIDTH  registered selected data
- out_chan  output  SEL_W  registered index of the source channel
- out_valid  output  1  output register holds data
- out_ready  input  1  consumer accepts data

## Operation
- Output register has two states:
  - EMPTY (out_valid=0)
  - FULL (out_valid=1)
- load = !out_valid | out_ready. The register can take new data this cycle.
- Grant g is computed combinationally from mode and in_valid:
  - fixed-select: g = sel. No grant if sel ≥ CHANNELS or !in_valid[sel].
  - fixed-priority: g = lowest index i with in_valid[i].
  - round-robin: g = first i with in_valid[i], searching ptr, ptr+1, … modulo CHANNELS.
- in_ready[i] = load & granted & (i == g) & !rst. All other in_ready bits are 0.
- Input transfer occurs when in_valid[g] & in_ready[g]. On that edge:
  - out_data ← channel g data
  - out_chan ← g
  - out_valid ← 1
- Output transfer occurs when out_valid & out_ready. If no input transfer happens on the same edge, out_valid ← 0 and out_data/out_chan hold their values.
- Simultaneous output and input transfer: the register is replaced and out_valid stays 1. This gives full throughput.
- Round-robin pointer ptr ← (g+1) mod CHANNELS on every input transfer in round-robin mode only. Wrap: g = CHANNELS-1 → ptr = 0. Other modes leave ptr unchanged.
- mode and sel are sampled every cycle with no latching. A change only affects the next grant; data already held in the register is unaffected.
- While FULL and !out_ready: out_data/out_chan are stable, all in_ready are 0, and ptr holds.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_chan=0, ptr=0
  - in_ready=0 during every cycle rst is high
- A reset asserted mid-operation discards held data on the next edge and ignores that cycle's inputs.
- Latency: input accepted at edge n → out_valid=1 after edge n, visible in cycle n+1.
- Throughput: 1 word/cycle with out_ready held high.
- No combinational path from in_valid to out_valid. The paths in_valid/mode/sel/out_ready → in_ready are combinational.

## Structure
- Shared package/header holds:
  - mode constants MODE_FIXED=2'b00, MODE_PRIO=2'b01, MODE_RR=2'b10
  - CHANNELS/WIDTH defaults
- One sub-module, rr_arbiter: inputs req[CHANNELS-1:0], ptr, priority_only; outputs grant index and grant_valid. It covers both the priority and round-robin search.
- The top module holds the output register, ptr, the fixed-select path and the in_ready decode.

## Test plan
All scenarios use WIDTH=8, CHANNELS=4.
- Reset: assert rst for 2 cycles with all in_valid=1. Required: in_ready=0, out_valid=0, out_data=0, out_chan=0; after release, first grant in RR mode is channel 0.
- Fixed-select: mode=00, sel=2, in_valid=4'b1111, data 8'hA0..8'hA3, out_ready=1. Required: out_data=8'hA2 and out_chan=2 every cycle, in_ready=4'b0100. With sel=3 and in_valid[3]=0, out_valid drops after one cycle.
- Fixed-priority: mode=01, in_valid=4'b1010. Required: channel 1 is always granted; channel 3 is granted only once in_valid[1] is deasserted.
- Round-robin fairness and wrap: mode=10, in_valid=4'b1111, out_ready=1 for 8 cycles. Required: out_chan sequence is 0,1,2,3,0,1,2,3.
- Backpressure: FULL with out_data=8'h55, out_ready=0 for 3 cycles. Required: out_data stays 8'h55, in_ready=0, ptr unchanged. Then raise out_ready with an input pending. Required: replacement on the same edge with out_valid staying 1.
- Reset mid-stream: assert rst while FULL and out_ready=0. Required: out_valid=0 and ptr=0 after the edge, and no input is accepted in that cycle.
